sm3_req_arb: RTL
================

SM3_REQ_ARB -- requirements
Module: sm3_req_arb

Interface
REQ-001 Parameter WDT_CYC, default 1024: idle-beat cycles before a watchdog abort; only used when SM3_ARB_WDT_EN is defined.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_i / req1_i  input  1 each  session request, requester 0 / 1.
REQ-005 d0_i / d1_i  input  32 each  message word, MSB-first bytes.
REQ-006 vb0_i / vb1_i  input  4 each  valid-byte mask of the word.
REQ-007 vld0_i / vld1_i  input  1 each  word valid.
REQ-008 lst0_i / lst1_i  input  1 each  last word of message.
REQ-009 rdy0_o / rdy1_o  output  1 each  word accepted when vldN_i & rdyN_o.
REQ-010 gnt0_o / gnt1_o  output  1 each  session owner; one-hot or zero.
REQ-011 done0_o / done1_o  output  1 each  one-cycle digest-ready pulse to the owner.
REQ-012 abort0_o / abort1_o  output  1 each  one-cycle pulse when the owner's session is watchdog-aborted.
REQ-013 msg_d_o  output  32  word to padder.
REQ-014 msg_vb_o  output  4  valid-byte mask to padder.
REQ-015 msg_vld_o  output  1  word valid to padder.
REQ-016 msg_lst_o  output  1  last flag to padder.
REQ-017 pad_rdy_i  input  1  padder ready.
REQ-018 pad_lst_i  input  1  padder final padded-word strobe.
REQ-019 dgst_vld_i  input  1  compression core digest valid, one-cycle pulse.

Function
REQ-020 FSM states: IDLE, GRANT, WAIT_PAD, WAIT_DGST.
REQ-021 IDLE: on any reqN_i, register the winner into gnt and go to GRANT next cycle; grant latency is 1 cycle.
REQ-022 Arbitration: round-robin on 1-bit last_gnt; on a tie the requester not equal to last_gnt wins; a single request always wins.
REQ-023 last_gnt updates to the winner on entry to GRANT.
REQ-024 GRANT: rdyN_o = pad_rdy_i & gntN_o; the non-owner's rdy is 0.
REQ-025 GRANT: msg_d_o, msg_vb_o and msg_lst_o are a combinational mux of the owner's inputs.
REQ-026 GRANT: msg_vld_o = owner vld & owner rdy.
REQ-027 Outside GRANT, msg_vld_o and msg_lst_o are 0 and msg_d_o/msg_vb_o are 0.
REQ-028 An accepted beat with lst = 1 moves the FSM to WAIT_PAD.
REQ-029 WAIT_PAD: wait for pad_lst_i, then go to WAIT_DGST.
REQ-030 WAIT_DGST: on dgst_vld_i, pulse the owner's doneN_o in the same cycle, clear gnt and return to IDLE.
REQ-031 In IDLE the arbiter evaluates requests on the next cycle; there is no back-to-back grant in the done cycle.
REQ-032 Deasserting reqN_i mid-session is ignored; the session ends only per REQ-030, or per REQ-038 when that feature is enabled.
REQ-033 Non-owner vld/lst inputs are ignored with no side effects.
REQ-034 pad_lst_i or dgst_vld_i arriving in a state that does not expect it is ignored.
REQ-035 Single-word message: vld & lst in the first GRANT cycle goes straight to WAIT_PAD.

Reset
REQ-036 On reset: FSM = IDLE, gnt = 0, last_gnt = 1 (requester 0 wins the first tie), watchdog counter = 0.
REQ-037 On reset all outputs are 0; reset mid-session discards the session without emitting doneN_o or abortN_o.

Configuration
REQ-038 With SM3_ARB_WDT_EN defined, the watchdog is active:
- A 16-bit counter increments each GRANT cycle with no accepted beat and clears on an accepted beat or on leaving GRANT.
- When the counter reaches WDT_CYC and pad_rdy_i = 1, the arbiter drives one flush beat: msg_vld_o = 1, msg_lst_o = 1, msg_vb_o = 0, msg_d_o = 0.
- In that cycle rdyN_o = 0 and abortN_o pulses to the owner.
- The FSM then goes to WAIT_PAD, and doneN_o still follows the digest.
REQ-039 Without SM3_ARB_WDT_EN, the counter, flush beat and abort pulse are absent, abortN_o is tied to 0, and GRANT waits indefinitely.

Verification
REQ-040 req0 only, 3 words with vb = 4'hF, the last with lst; pad_lst_i then dgst_vld_i -> gnt0_o rises 1 cycle after req0, 3 msg_vld_o beats, done0_o one pulse, then IDLE.
REQ-041 req0 and req1 both asserted after reset -> owner 0 first; with both held after done, owner 1 next; then owner 0 again (alternation).
REQ-042 Owner 1 with pad_rdy_i low for 5 cycles while vld1_i = 1 -> rdy1_o = 0 and msg_vld_o = 0 for those cycles; the word is passed exactly once when pad_rdy_i rises.
REQ-043 Non-owner drives vld/lst during owner's session -> rdy of the non-owner = 0, msg_* unaffected, owner's done unaffected.
REQ-044 With SM3_ARB_WDT_EN, WDT_CYC = 8, owner 0 sends 1 word then idles -> after 8 idle cycles: flush beat (vb 0, lst 1), abort0_o pulse, done0_o after dgst_vld_i. Without the macro: no flush.
REQ-045 rst_n asserted in WAIT_PAD -> all outputs 0 immediately; after release, a fresh req1 is granted within 1 cycle.

Source files
------------

// File: rtl/sm3_req_arb.sv
// Two-requester round-robin session arbiter in front of the SM3 padder; grant lands 1 cycle after request,
// the owner's rdy follows pad_rdy_i. Optional watchdog flush/abort is built only when SM3_ARB_WDT_EN is defined.
module sm3_req_arb #(
   parameter int WDT_CYC = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_i,
   input  logic        req1_i,
   input  logic [31:0] d0_i,
   input  logic [31:0] d1_i,
   input  logic [3:0]  vb0_i,
   input  logic [3:0]  vb1_i,
   input  logic        vld0_i,
   input  logic        vld1_i,
   input  logic        lst0_i,
   input  logic        lst1_i,
   output logic        rdy0_o,
   output logic        rdy1_o,
   output logic        gnt0_o,
   output logic        gnt1_o,
   output logic        done0_o,
   output logic        done1_o,
   output logic        abort0_o,
   output logic        abort1_o,
   output logic [31:0] msg_d_o,
   output logic [3:0]  msg_vb_o,
   output logic        msg_vld_o,
   output logic        msg_lst_o,
   input  logic        pad_rdy_i,
   input  logic        pad_lst_i,
   input  logic        dgst_vld_i
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_GRANT     = 2'd1;
   localparam logic [1:0] ST_WAIT_PAD  = 2'd2;
   localparam logic [1:0] ST_WAIT_DGST = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [1:0]  gnt_q, gnt_d;
   logic        last_gnt_q, last_gnt_d;

   logic        in_grant;
   logic        own;
   logic        own_vld;
   logic        own_lst;
   logic [31:0] own_d;
   logic [3:0]  own_vb;
   logic        win;
   logic        flush;
   logic        beat_acc;

   assign in_grant = (state_q == ST_GRANT);
   assign own      = gnt_q[1];
   assign own_vld  = own ? vld1_i : vld0_i;
   assign own_lst  = own ? lst1_i : lst0_i;
   assign own_d    = own ? d1_i   : d0_i;
   assign own_vb   = own ? vb1_i  : vb0_i;

   // Tie goes to whoever did not win last; a lone request always wins.
   assign win = (req0_i & req1_i) ? ~last_gnt_q : req1_i;

   assign beat_acc = in_grant & own_vld & pad_rdy_i & ~flush;

`ifdef SM3_ARB_WDT_EN
   logic [15:0] wdt_q, wdt_d;
   logic        wdt_hit;

   assign wdt_hit = in_grant & (wdt_q == 16'(WDT_CYC));
   assign flush   = wdt_hit & pad_rdy_i;

   // Saturates at the limit while the padder stalls, so the flush fires as soon as it is ready.
   always_comb begin
      wdt_d = 16'd0;
      if (in_grant && (state_d == ST_GRANT) && !beat_acc) begin
         wdt_d = wdt_hit ? wdt_q : wdt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdt_q <= 16'd0;
      end else begin
         wdt_q <= wdt_d;
      end
   end
`else
   logic unused_wdt;
   assign unused_wdt = (WDT_CYC == 0);
   assign flush      = 1'b0;
`endif

   assign gnt0_o   = gnt_q[0];
   assign gnt1_o   = gnt_q[1];
   assign rdy0_o   = in_grant & pad_rdy_i & gnt_q[0] & ~flush;
   assign rdy1_o   = in_grant & pad_rdy_i & gnt_q[1] & ~flush;
   assign done0_o  = (state_q == ST_WAIT_DGST) & dgst_vld_i & gnt_q[0];
   assign done1_o  = (state_q == ST_WAIT_DGST) & dgst_vld_i & gnt_q[1];
   assign abort0_o = flush & gnt_q[0];
   assign abort1_o = flush & gnt_q[1];

   always_comb begin
      msg_d_o   = 32'd0;
      msg_vb_o  = 4'd0;
      msg_vld_o = 1'b0;
      msg_lst_o = 1'b0;
      if (in_grant) begin
         if (flush) begin
            msg_vld_o = 1'b1;
            msg_lst_o = 1'b1;
         end else begin
            msg_d_o   = own_d;
            msg_vb_o  = own_vb;
            msg_lst_o = own_lst;
            msg_vld_o = beat_acc;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_gnt_d = last_gnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req0_i || req1_i) begin
               gnt_d      = win ? 2'b10 : 2'b01;
               last_gnt_d = win;
               state_d    = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (flush || (beat_acc && own_lst)) begin
               state_d = ST_WAIT_PAD;
            end
         end
         ST_WAIT_PAD: begin
            if (pad_lst_i) begin
               state_d = ST_WAIT_DGST;
            end
         end
         ST_WAIT_DGST: begin
            if (dgst_vld_i) begin
               gnt_d   = 2'b00;
               state_d = ST_IDLE;
            end
         end
         default: begin
            gnt_d   = 2'b00;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gnt_q      <= 2'b00;
         last_gnt_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_gnt_q <= last_gnt_d;
      end
   end

endmodule
